// File: rtl/serial_tofed_tx_pkg.sv
// Shared definitions for the Serial TOFED 2-of-5 transmitter: frame geometry,
// FSM state type and the weighted 7-4-2-1-0 codeword table.
package serial_tofed_tx_pkg;

  localparam int FBIBBLE_SIZE   = 5;
  localparam int ONESPERFBIBBLE = 2;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  typedef enum logic {
    TX_IDLE  = 1'b0,
    TX_SHIFT = 1'b1
  } tx_state_t;

  // Digit to 2-of-5 codeword, MSB first; non-decimal digits map to all zeros
  // so the far-end detector sees an illegal (zero-ones) frame.
  function automatic logic [FBIBBLE_SIZE-1:0] encode_2of5(input logic [3:0] digit);
    logic [FBIBBLE_SIZE-1:0] code;
    code = 5'b00000;
    if (digit <= DIGIT_MAX) begin
      case (digit)
        4'd0:    code = 5'b11000;
        4'd1:    code = 5'b00011;
        4'd2:    code = 5'b00101;
        4'd3:    code = 5'b00110;
        4'd4:    code = 5'b01001;
        4'd5:    code = 5'b01010;
        4'd6:    code = 5'b01100;
        4'd7:    code = 5'b10001;
        4'd8:    code = 5'b10010;
        4'd9:    code = 5'b10100;
        default: code = 5'b00000;
      endcase
    end else begin
      code = 5'b00000;
    end
    return code;
  endfunction

  // True when a codeword carries exactly the legal number of ones.
  function automatic logic is_legal_2of5(input logic [FBIBBLE_SIZE-1:0] code);
    return ($countones(code) == ONESPERFBIBBLE);
  endfunction

endpackage

// File: rtl/serial_tofed_tx_if.sv
// Digit source / serial link bundle for the 2-of-5 transmitter.
// The slave side is the transmitter; the master side feeds digits and
// observes the serial stream.
interface serial_tofed_tx_if;

  logic [3:0] digit;
  logic       digit_valid;
  logic       inject_err;
  logic       ready;
  logic       out;
  logic       frame_start;
  logic [7:0] frames_sent;

  modport slave (
    input  digit, digit_valid, inject_err,
    output ready, out, frame_start, frames_sent
  );

  modport master (
    output digit, digit_valid, inject_err,
    input  ready, out, frame_start, frames_sent
  );

endinterface

// File: rtl/serial_tofed_tx_encoder.sv
// Combinational 2-of-5 encoder with test-only error injection: a set
// inject_err_i flips the codeword LSB so the frame no longer has two ones.
module serial_tofed_tx_encoder
  import serial_tofed_tx_pkg::*;
(
  input  logic [3:0]              digit_i,
  input  logic                    inject_err_i,
  output logic [FBIBBLE_SIZE-1:0] code_o
);

  assign code_o = encode_2of5(digit_i) ^ {{(FBIBBLE_SIZE-1){1'b0}}, inject_err_i};

endmodule

// File: rtl/serial_tofed_tx.sv
// Serial 2-of-5 transmitter: accepts a digit when ready, shifts its codeword
// out MSB first one bit per clock, and chains frames with no idle bit when
// the next digit is offered during the last bit of the current frame.
module serial_tofed_tx
  import serial_tofed_tx_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  serial_tofed_tx_if.slave  bus
);

  localparam logic [2:0] LAST_BIT = 3'(FBIBBLE_SIZE - 1);

  tx_state_t               state_q;
  logic [2:0]              bit_cnt_q;
  logic [FBIBBLE_SIZE-1:0] shreg_q;
  logic [7:0]              frames_q;
  logic                    ready_q;
  logic                    frame_start_q;
  logic [FBIBBLE_SIZE-1:0] code_s;
  logic                    accept_s;

  serial_tofed_tx_encoder u_encoder (
    .digit_i      (bus.digit),
    .inject_err_i (bus.inject_err),
    .code_o       (code_s)
  );

  assign accept_s = bus.digit_valid && ready_q;

  // Transmit FSM with shift register, bit counter, frame counter and registered flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= TX_IDLE;
      bit_cnt_q     <= 3'd0;
      shreg_q       <= 5'b00000;
      frames_q      <= 8'd0;
      ready_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (accept_s) begin
            state_q       <= TX_SHIFT;
            bit_cnt_q     <= 3'd0;
            shreg_q       <= code_s;
            ready_q       <= 1'b0;
            frame_start_q <= 1'b1;
          end else begin
            ready_q       <= 1'b1;
            frame_start_q <= 1'b0;
          end
        end
        TX_SHIFT: begin
          if (bit_cnt_q == LAST_BIT) begin
            frames_q <= frames_q + 8'd1;
            if (accept_s) begin
              // Back-to-back frame: reload without an idle bit.
              bit_cnt_q     <= 3'd0;
              shreg_q       <= code_s;
              ready_q       <= 1'b0;
              frame_start_q <= 1'b1;
            end else begin
              state_q       <= TX_IDLE;
              bit_cnt_q     <= 3'd0;
              shreg_q       <= 5'b00000;
              ready_q       <= 1'b1;
              frame_start_q <= 1'b0;
            end
          end else begin
            shreg_q       <= {shreg_q[FBIBBLE_SIZE-2:0], 1'b0};
            bit_cnt_q     <= bit_cnt_q + 3'd1;
            ready_q       <= ((bit_cnt_q + 3'd1) == LAST_BIT);
            frame_start_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= TX_IDLE;
          bit_cnt_q     <= 3'd0;
          shreg_q       <= 5'b00000;
          ready_q       <= 1'b1;
          frame_start_q <= 1'b0;
        end
      endcase
    end
  end

  // The shift register is all zeros whenever idle, so its MSB is the line value.
  assign bus.out         = shreg_q[FBIBBLE_SIZE-1];
  assign bus.ready       = ready_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frames_sent = frames_q;

endmodule
